pokey_bus_arbiter: RTL and testbench
====================================

POKEY_BUS_ARBITER -- requirements
Module: pokey_bus_arbiter

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles the address, data and chip select are held with phi2 low before the phi2 rising edge; legal range 1..15.
REQ-002 Parameter HIGH_CYC, default 4: cycles phi2 is held high; legal range 2..15.
REQ-003 clk  in  1  single block clock; all state changes on its rising edge.
REQ-004 clrBar  in  1  reset, asynchronous assert, active-low.
REQ-005 reqN_valid  in  1  requester N (N=0,1) has a POKEY access pending.
REQ-006 reqN_ready  out  1  requester N's access is accepted this cycle.
REQ-007 reqN_addr  in  4  POKEY register address for requester N.
REQ-008 reqN_wdata  in  8  write data for requester N.
REQ-009 reqN_rnw  in  1  1 means read, 0 means write.
REQ-010 rspN_valid  out  1  one-cycle completion pulse to requester N.
REQ-011 rspN_rdata  out  8  read data for requester N; valid only while rspN_valid is high.
REQ-012 pk_a  out  4  POKEY address A.
REQ-013 pk_din  out  8  POKEY Din.
REQ-014 pk_dout  in  8  POKEY Dout.
REQ-015 pk_rnw  out  1  POKEY readHighWriteLow.
REQ-016 pk_cs0Bar  out  1  POKEY chip select, active-low.
REQ-017 pk_phi2  out  1  POKEY phi2.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have four states: IDLE, SETUP, HIGH and RELEASE.
REQ-020 Arbitration SHALL be round-robin: if only one requester is valid in IDLE, that requester is granted.
REQ-021 If both requesters are valid in IDLE, the requester not granted most recently SHALL be granted; after reset the last-grant pointer SHALL indicate req1, so req0 wins the first tie.
REQ-022 reqN_ready SHALL be combinational and SHALL equal (state==IDLE) & grantN; at most one ready SHALL be high in any cycle.
REQ-023 When valid&ready, the block SHALL latch addr, wdata, rnw and the requester ID, update the last-grant pointer, and go to SETUP.
REQ-024 Requesters SHALL hold valid and their fields stable until ready; the block SHALL ignore the fields except in the acceptance cycle.
REQ-025 In SETUP, for SETUP_CYC cycles, the block SHALL drive pk_a, pk_din and pk_rnw from the latched values, drive pk_cs0Bar=0 and pk_phi2=0, then go to HIGH.
REQ-026 In HIGH, for HIGH_CYC cycles, the block SHALL keep pk_a, pk_din, pk_rnw and pk_cs0Bar unchanged and drive pk_phi2=1.
REQ-027 On the last HIGH cycle of a read, the block SHALL capture pk_dout; the bus-side value is guaranteed stable from the second HIGH cycle.
REQ-028 In RELEASE, lasting 1 cycle, the block SHALL drive pk_phi2=0 and pk_cs0Bar=1 and pulse rsp_valid for the latched ID.
REQ-029 For a read, rsp_rdata SHALL equal the captured pk_dout; for a write, rsp_rdata SHALL be 8'h00. After RELEASE the FSM SHALL return to IDLE.
REQ-030 All pk_* outputs SHALL be registered and glitch-free; exactly one phi2 rising edge SHALL occur per accepted access, and none in IDLE.
REQ-031 Latency SHALL be SETUP_CYC+HIGH_CYC+1 cycles from the acceptance edge to rsp_valid (7 cycles at the defaults); a new access can be accepted in the IDLE cycle after RELEASE, giving a minimum period of SETUP_CYC+HIGH_CYC+2 cycles.
REQ-032 In IDLE, pk_a, pk_din and pk_rnw SHALL hold their last driven values, with pk_cs0Bar=1 and pk_phi2=0.
REQ-033 A requester that drops valid before ready SHALL NOT be granted; it is a protocol violation, and there is no required behaviour beyond "no bus cycle issued".
REQ-034 A requester reasserting valid in the same cycle as its own rsp_valid SHALL be accepted no earlier than the following IDLE cycle.

Reset
REQ-035 While clrBar=0, the block SHALL be held in reset immediately, independent of clk: state=IDLE, pk_phi2=0, pk_cs0Bar=1, pk_rnw=1, pk_a=0, pk_din=0, both ready=0, both rsp_valid=0, both rsp_rdata=0, busy=0, last-grant=req1.
REQ-036 Reset asserted mid-access SHALL abort the access with no rsp_valid; a phi2 that is high SHALL drop in the same instant.
REQ-037 After clrBar deasserts, the first acceptance SHALL occur no earlier than the first clk rising edge.

Verification
REQ-038 req0 writes addr 4'h1, data 8'hA5 -> pk_cs0Bar low for 6 cycles with pk_a=1, pk_din=A5 and pk_rnw=0 throughout, one phi2 rise after 2 cycles, rsp0_valid 7 cycles after acceptance, rsp0_rdata=00.
REQ-039 req1 reads addr 4'hA with the POKEY model returning 8'h3C from the second HIGH cycle -> rsp1_valid with rsp1_rdata=3C, and rsp0_valid stays 0.
REQ-040 req0 and req1 both valid continuously from reset -> grants alternate 0,1,0,1 with acceptances 8 cycles apart, and ready is never high for both.
REQ-041 clrBar pulsed low during the HIGH state of a read -> phi2=0 and cs0Bar=1 asynchronously, no rsp pulse, and the next access completes normally.
REQ-042 SETUP_CYC=1, HIGH_CYC=2, single write -> rsp_valid 4 cycles after acceptance, exactly one phi2 rising edge.
REQ-043 req0 drops valid in IDLE while the FSM is busy with req1 -> no req0 bus cycle is issued and busy falls after req1's RELEASE.

Source files
------------

// File: rtl/pokey_bus_arbiter_if.sv
// pokey_bus_arbiter_if: two requester ports plus the POKEY pin bus, with slave (arbiter) and master (requesters/POKEY) views
// Ports: reqN_* requester handshake and fields, rspN_* completion, pk_* POKEY pins, busy status
interface pokey_bus_arbiter_if;
  logic       req0_valid, req0_ready, req0_rnw;
  logic [3:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       req1_valid, req1_ready, req1_rnw;
  logic [3:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [3:0] pk_a;
  logic [7:0] pk_din, pk_dout;
  logic       pk_rnw, pk_cs0Bar, pk_phi2;
  logic       busy;
  modport slave (
    input  req0_valid, req0_addr, req0_wdata, req0_rnw,
    input  req1_valid, req1_addr, req1_wdata, req1_rnw, pk_dout,
    output req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output pk_a, pk_din, pk_rnw, pk_cs0Bar, pk_phi2, busy
  );
  modport master (
    output req0_valid, req0_addr, req0_wdata, req0_rnw,
    output req1_valid, req1_addr, req1_wdata, req1_rnw, pk_dout,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  pk_a, pk_din, pk_rnw, pk_cs0Bar, pk_phi2, busy
  );
endinterface

// File: rtl/pokey_bus_arbiter.sv
// pokey_bus_arbiter: round-robin arbiter turning two requesters' accesses into POKEY phi2 bus cycles
// Ports: clk, clrBar (async active-low reset), bus (pokey_bus_arbiter_if.slave)
module pokey_bus_arbiter #(
  parameter int SETUP_CYC = 2,
  parameter int HIGH_CYC  = 4
) (
  input logic clk,
  input logic clrBar,
  pokey_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, RELEASE} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       last, id, grant0, grant1;
  // last=1 means req1 was granted most recently, so req0 wins a tie
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last);
  // gated by clrBar so no ready is offered while reset is held
  assign bus.req0_ready = clrBar & (state == IDLE) & grant0;
  assign bus.req1_ready = clrBar & (state == IDLE) & grant1;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      state          <= IDLE;
      cnt            <= '0;
      last           <= 1'b1;
      id             <= 1'b0;
      bus.pk_a       <= '0;
      bus.pk_din     <= '0;
      bus.pk_rnw     <= 1'b1;
      bus.pk_cs0Bar  <= 1'b1;
      bus.pk_phi2    <= 1'b0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp0_rdata <= '0;
      bus.rsp1_rdata <= '0;
    end else begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp0_rdata <= '0;
      bus.rsp1_rdata <= '0;
      case (state)
        IDLE: if (grant0 | grant1) begin
          id            <= grant1;
          last          <= grant1;
          bus.pk_a      <= grant1 ? bus.req1_addr  : bus.req0_addr;
          bus.pk_din    <= grant1 ? bus.req1_wdata : bus.req0_wdata;
          bus.pk_rnw    <= grant1 ? bus.req1_rnw   : bus.req0_rnw;
          bus.pk_cs0Bar <= 1'b0;
          cnt           <= 4'(SETUP_CYC - 1);
          state         <= SETUP;
        end
        SETUP: if (cnt == 4'd0) begin
          bus.pk_phi2 <= 1'b1;
          cnt         <= 4'(HIGH_CYC - 1);
          state       <= HIGH;
        end else cnt <= cnt - 4'd1;
        // the edge leaving the last HIGH cycle captures pk_dout and launches the response
        HIGH: if (cnt == 4'd0) begin
          bus.pk_phi2    <= 1'b0;
          bus.pk_cs0Bar  <= 1'b1;
          bus.rsp0_valid <= ~id;
          bus.rsp1_valid <= id;
          bus.rsp0_rdata <= (~id & bus.pk_rnw) ? bus.pk_dout : 8'h00;
          bus.rsp1_rdata <= (id & bus.pk_rnw) ? bus.pk_dout : 8'h00;
          state          <= RELEASE;
        end else cnt <= cnt - 4'd1;
        RELEASE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pokey_bus_arbiter.sv
// tb_pokey_bus_arbiter: directed scoreboard bench for pokey_bus_arbiter (defaults and SETUP_CYC=1/HIGH_CYC=2)
module tb_pokey_bus_arbiter;
  logic clk = 1'b0;
  logic clrBar = 1'b1;
  int tests = 0, fails = 0, cyc = 0;
  int acc_cnt = 0, rsp_cnt = 0, last_rsp_cyc = 0, rises = 0;
  logic phi2_q = 1'b0;
  logic [7:0] rd_tbl [16];
  logic [3:0] hcnt = '0;
  typedef struct {logic id; logic [7:0] data; int cyc; int rises;} exp_t;
  exp_t sb [$];
  exp_t gl [$];
  pokey_bus_arbiter_if ifa ();
  pokey_bus_arbiter_if ifb ();
  pokey_bus_arbiter dut_a (.clk(clk), .clrBar(clrBar), .bus(ifa.slave));
  pokey_bus_arbiter #(.SETUP_CYC(1), .HIGH_CYC(2)) dut_b (.clk(clk), .clrBar(clrBar), .bus(ifb.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // POKEY model: Dout valid only from the second phi2-high cycle, junk before that
  always @(posedge clk) hcnt <= ifa.pk_phi2 ? hcnt + 4'd1 : 4'd0;
  assign ifa.pk_dout = (ifa.pk_phi2 && hcnt != 4'd0) ? rd_tbl[ifa.pk_a] : 8'hEE;
  assign ifb.pk_dout = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifa.pk_phi2 && !phi2_q) rises++;
    phi2_q = ifa.pk_phi2;
    if (ifa.req0_ready || ifa.req1_ready) chk("ready_onehot", {31'd0, ifa.req0_ready & ifa.req1_ready}, 0);
    if (ifa.rsp0_valid || ifa.rsp1_valid) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_both", {31'd0, ifa.rsp0_valid & ifa.rsp1_valid}, 0);
        chk("rsp_id", {31'd0, ifa.rsp1_valid}, {31'd0, e.id});
        chk("rsp_rdata", {24'd0, ifa.rsp1_valid ? ifa.rsp1_rdata : ifa.rsp0_rdata}, {24'd0, e.data});
        chk("rsp_latency", cyc - e.cyc, 7);
        chk("phi2_rises", rises - e.rises, 1);
      end
    end
    if ((ifa.req0_valid && ifa.req0_ready) || (ifa.req1_valid && ifa.req1_ready)) begin
      exp_t e;
      e.id = ifa.req1_ready;
      e.data = e.id ? (ifa.req1_rnw ? rd_tbl[ifa.req1_addr] : 8'h00) : (ifa.req0_rnw ? rd_tbl[ifa.req0_addr] : 8'h00);
      e.cyc = cyc;
      e.rises = rises;
      sb.push_back(e);
      gl.push_back(e);
      acc_cnt++;
    end
  end

  task automatic do_req(input logic id, input logic [3:0] a, input logic [7:0] d, input logic r);
    bit ok = 0;
    if (id) begin ifa.req1_addr = a; ifa.req1_wdata = d; ifa.req1_rnw = r; ifa.req1_valid = 1'b1; end
    else begin ifa.req0_addr = a; ifa.req0_wdata = d; ifa.req0_rnw = r; ifa.req0_valid = 1'b1; end
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = id ? ifa.req1_ready : ifa.req0_ready;
    end
    chk("accept_in_time", {31'd0, ok}, 1);
    @(posedge clk); #1;
    if (id) ifa.req1_valid = 1'b0; else ifa.req0_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowc, first_hi, acc0, cyc_rel, acc_c, lat, rb, rdb;
    bit ok;
    for (int i = 0; i < 16; i++) rd_tbl[i] = 8'(i * 17);
    rd_tbl[10] = 8'h3C;
    {ifa.req0_valid, ifa.req1_valid, ifb.req0_valid, ifb.req1_valid} = '0;
    {ifa.req0_addr, ifa.req1_addr, ifb.req0_addr, ifb.req1_addr} = '0;
    {ifa.req0_wdata, ifa.req1_wdata, ifb.req0_wdata, ifb.req1_wdata} = '0;
    {ifa.req0_rnw, ifa.req1_rnw, ifb.req0_rnw, ifb.req1_rnw} = '1;
    #1 clrBar = 1'b0;
    #2 ifa.req0_valid = 1'b1;
    #1;
    chk("rst_phi2", {31'd0, ifa.pk_phi2}, 0);
    chk("rst_cs", {31'd0, ifa.pk_cs0Bar}, 1);
    chk("rst_rnw", {31'd0, ifa.pk_rnw}, 1);
    chk("rst_a", {28'd0, ifa.pk_a}, 0);
    chk("rst_din", {24'd0, ifa.pk_din}, 0);
    chk("rst_ready0", {31'd0, ifa.req0_ready}, 0);
    chk("rst_ready1", {31'd0, ifa.req1_ready}, 0);
    chk("rst_rsp", {30'd0, ifa.rsp0_valid, ifa.rsp1_valid}, 0);
    chk("rst_rdata", {16'd0, ifa.rsp0_rdata, ifa.rsp1_rdata}, 0);
    chk("rst_busy", {31'd0, ifa.busy}, 0);
    ifa.req0_valid = 1'b0;
    tick(2);
    clrBar = 1'b1;
    tick(1);
    do_req(0, 4'h1, 8'hA5, 1'b0);
    lowc = 0; first_hi = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!ifa.pk_cs0Bar) begin
        lowc++;
        chk("wr_pk_a", {28'd0, ifa.pk_a}, 1);
        chk("wr_pk_din", {24'd0, ifa.pk_din}, 32'hA5);
        chk("wr_pk_rnw", {31'd0, ifa.pk_rnw}, 0);
      end
      if (ifa.pk_phi2 && first_hi == 0) first_hi = k;
    end
    chk("wr_cs_low_cycles", lowc, 6);
    chk("wr_phi2_first_high", first_hi, 3);
    tick(1);
    do_req(1, 4'hA, 8'h00, 1'b1);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("rd_rsp0_quiet", {31'd0, ifa.rsp0_valid}, 0);
    end
    chk("rd_done", rsp_cnt, 2);
    tick(1);
    do_req(1, 4'h5, 8'h00, 1'b1);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin @(negedge clk); ok = ifa.pk_phi2; end
    chk("abort_reached_high", {31'd0, ok}, 1);
    #2 clrBar = 1'b0;
    #1;
    chk("abort_phi2", {31'd0, ifa.pk_phi2}, 0);
    chk("abort_cs", {31'd0, ifa.pk_cs0Bar}, 1);
    chk("abort_busy", {31'd0, ifa.busy}, 0);
    sb.delete();
    tick(2);
    #2 clrBar = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", {30'd0, ifa.rsp0_valid, ifa.rsp1_valid}, 0);
    end
    tick(1);
    acc0 = rsp_cnt;
    do_req(0, 4'h2, 8'h5A, 1'b0);
    tick(9);
    chk("post_abort_done", rsp_cnt - acc0, 1);
    acc0 = acc_cnt;
    do_req(1, 4'hA, 8'h00, 1'b1);
    ifa.req0_valid = 1'b1;
    ifa.req0_addr = 4'h7;
    ifa.req0_wdata = 8'h99;
    ifa.req0_rnw = 1'b0;
    @(negedge clk);
    chk("drop_ready0_busy", {31'd0, ifa.req0_ready}, 0);
    tick(1);
    ifa.req0_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = !ifa.busy; end
    chk("drop_busy_fell", {31'd0, ok}, 1);
    chk("drop_busy_after_release", cyc - last_rsp_cyc, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("drop_no_cycle", {30'd0, ifa.pk_cs0Bar, ifa.busy}, 2);
    end
    chk("drop_acceptances", acc_cnt - acc0, 1);
    tick(1);
    clrBar = 1'b0;
    ifa.req0_addr = 4'h3; ifa.req0_wdata = 8'h11; ifa.req0_rnw = 1'b0;
    ifa.req1_addr = 4'h4; ifa.req1_wdata = 8'h22; ifa.req1_rnw = 1'b0;
    ifa.req0_valid = 1'b1;
    ifa.req1_valid = 1'b1;
    #2;
    chk("rr_rst_ready", {30'd0, ifa.req0_ready, ifa.req1_ready}, 0);
    gl.delete();
    tick(1);
    clrBar = 1'b1;
    cyc_rel = cyc;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = gl.size() >= 4; end
    chk("rr_four_grants", {31'd0, ok}, 1);
    tick(1);
    ifa.req0_valid = 1'b0;
    ifa.req1_valid = 1'b0;
    if (ok) begin
      chk("rr_first_edge", gl[0].cyc, cyc_rel);
      for (int g = 0; g < 4; g++) chk("rr_grant_id", {31'd0, gl[g].id}, g % 2);
      for (int g = 1; g < 4; g++) chk("rr_spacing", gl[g].cyc - gl[g-1].cyc, 8);
    end
    tick(12);
    chk("sb_drained", sb.size(), 0);
    ifb.req0_addr = 4'h6; ifb.req0_wdata = 8'h42; ifb.req0_rnw = 1'b0;
    ifb.req0_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin @(negedge clk); ok = ifb.req0_ready; end
    chk("b_accept", {31'd0, ok}, 1);
    acc_c = cyc;
    tick(1);
    ifb.req0_valid = 1'b0;
    lat = 0; rb = 0; rdb = 0;
    ok = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ifb.pk_phi2 && !ok) rb++;
      ok = ifb.pk_phi2;
      if (ifb.rsp0_valid) begin lat = cyc - acc_c; rdb = ifb.rsp0_rdata; end
    end
    chk("b_latency", lat, 4);
    chk("b_phi2_rises", rb, 1);
    chk("b_rdata", rdb, 0);
    chk("b_busy_end", {31'd0, ifb.busy}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
